// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Frame layout, state encoding and field widths live here.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int LOADER_WORD_BYTES = 4;
    localparam int LOADER_CNT_W      = 16;
    localparam int LOADER_LANE_W     = 2;
    localparam int LOADER_POS_CNT_LO = 0;
    localparam int LOADER_POS_CNT_HI = 1;

    // Byte acceptance is decoded purely from the state.
    function automatic logic is_loading(input state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) ||
               (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_packer.sv
// Byte-to-word assembler: little-endian lane counter and shift register.
// Pulses o_word_valid combinationally as the lane-3 byte is accepted.
import prog_loader_pkg::*;

module byte_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [LOADER_LANE_W-1:0] r_lane;
    logic [23:0]              r_shift;
    logic                     w_last;

    assign w_last       = (r_lane == LOADER_LANE_W'(LOADER_WORD_BYTES - 1));
    assign o_word_valid = i_en & w_last;
    assign o_word       = {i_byte, r_shift};

    // Lane counter and the three lower bytes of the word in flight
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (i_en) begin
            r_lane  <= r_lane + LOADER_LANE_W'(1);
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: framed byte stream -> instruction memory words.
// Holds the CPU in reset until a frame with a good checksum lands.
import prog_loader_pkg::*;

module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    input  logic              i_reload,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned CAP = 2 ** ADDR_W;

    state_t                  r_state;
    state_t                  w_next;
    logic [7:0]              r_cnt_lo;
    logic [LOADER_CNT_W-1:0] r_remain;
    logic [7:0]              r_csum;
    logic [ADDR_W-1:0]       r_waddr;

    logic                    w_accept;
    logic [LOADER_CNT_W-1:0] w_count;
    logic                    w_oversize;
    logic                    w_data_en;
    logic                    w_restart;
    logic                    w_word_valid;
    logic [31:0]             w_word;

    assign w_accept   = i_byte_valid & o_byte_ready;
    assign w_count    = {i_byte_data, r_cnt_lo};
    assign w_oversize = 32'(w_count) > CAP;
    assign w_data_en  = w_accept & (r_state == ST_DATA);
    assign w_restart  = i_reload &
                        ((r_state == ST_RUN) || (r_state == ST_ERR));

    byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (w_restart),
        .i_en         (w_data_en),
        .i_byte       (i_byte_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= ST_HDR0;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_HDR0: if (w_accept) w_next = ST_HDR1;
            ST_HDR1: begin
                if (w_accept) begin
                    if (w_oversize)          w_next = ST_ERR;
                    else if (w_count == '0)  w_next = ST_CSUM;
                    else                     w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_valid && r_remain == LOADER_CNT_W'(1))
                    w_next = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_accept)
                    w_next = (i_byte_data == r_csum) ? ST_RUN : ST_ERR;
            end
            ST_RUN:  if (i_reload) w_next = ST_HDR0;
            ST_ERR:  if (i_reload) w_next = ST_HDR0;
            default: w_next = ST_HDR0;
        endcase
    end

    // Status outputs decoded from state only
    always_comb begin
        o_byte_ready = is_loading(r_state);
        o_done       = (r_state == ST_RUN);
        o_err        = (r_state == ST_ERR);
        o_cpu_rst    = (r_state == ST_RUN);
    end

    // Header count, words remaining, running checksum, write address
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt_lo <= '0;
            r_remain <= '0;
            r_csum   <= '0;
            r_waddr  <= '0;
        end else if (w_restart) begin
            r_csum   <= '0;
            r_waddr  <= '0;
        end else begin
            if (w_accept && r_state != ST_CSUM)
                r_csum <= r_csum ^ i_byte_data;
            if (w_accept && r_state == ST_HDR0)
                r_cnt_lo <= i_byte_data;
            if (w_accept && r_state == ST_HDR1)
                r_remain <= w_count;
            if (w_word_valid) begin
                r_remain <= r_remain - LOADER_CNT_W'(1);
                r_waddr  <= r_waddr + ADDR_W'(1);
            end
        end
    end

    // Registered instruction-memory write port, one cycle after lane 3
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
        end else begin
            o_imem_we <= w_word_valid;
            if (w_word_valid) begin
                o_imem_addr  <= r_waddr;
                o_imem_wdata <= w_word;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader at two memory sizes.
// A frame-position model predicts every output each cycle.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        reload;

    logic        rdy0, we0, cpu0, done0, err0;
    logic [9:0]  addr0;
    logic [31:0] wd0;
    logic        rdy1, we1, cpu1, done1, err1;
    logic [1:0]  addr1;
    logic [31:0] wd1;

    prog_loader #(.ADDR_W(10)) u_big (
        .i_clk(clk), .i_rst(rst), .i_byte_valid(valid),
        .i_byte_data(data), .o_byte_ready(rdy0), .i_reload(reload),
        .o_imem_we(we0), .o_imem_addr(addr0), .o_imem_wdata(wd0),
        .o_cpu_rst(cpu0), .o_done(done0), .o_err(err0)
    );

    prog_loader #(.ADDR_W(2)) u_small (
        .i_clk(clk), .i_rst(rst), .i_byte_valid(valid),
        .i_byte_data(data), .o_byte_ready(rdy1), .i_reload(reload),
        .o_imem_we(we1), .o_imem_addr(addr1), .o_imem_wdata(wd1),
        .o_cpu_rst(cpu1), .o_done(done1), .o_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    task automatic chk(input string nm, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t got=%h expected=%h",
                     nm, k, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned cap [2];
    bit          m_load [2];
    int          m_pos [2];
    int          m_n [2];
    logic [7:0]  m_csum [2];
    logic [31:0] m_word [2];
    bit          m_done [2];
    bit          m_err [2];
    bit          m_we [2];
    int          m_addr [2];
    logic [31:0] m_wdata [2];
    int          m_nwr [2];
    int          q_addr [$];
    logic [31:0] q_data [$];

    initial begin
        cap[0] = 1024;
        cap[1] = 4;
    end

    task automatic model_step();
        int p;
        int j;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_load[k] = 1; m_pos[k] = 0; m_n[k] = 0;
                m_csum[k] = 0; m_word[k] = 0;
                m_done[k] = 0; m_err[k] = 0; m_we[k] = 0;
            end else begin
                m_we[k] = 0;
                if (m_load[k] && valid) begin
                    p = m_pos[k];
                    if (p == 0) begin
                        m_n[k] = int'(data);
                        m_csum[k] ^= data;
                    end else if (p == 1) begin
                        m_n[k] += int'(data) * 256;
                        m_csum[k] ^= data;
                        if (m_n[k] > int'(cap[k])) begin
                            m_load[k] = 0;
                            m_err[k] = 1;
                        end
                    end else if (p < 2 + 4 * m_n[k]) begin
                        j = p - 2;
                        m_csum[k] ^= data;
                        if (j % 4 == 0) m_word[k] = 0;
                        m_word[k] |= 32'(data) << (8 * (j % 4));
                        if (j % 4 == 3) begin
                            m_we[k] = 1;
                            m_addr[k] = (j / 4) % int'(cap[k]);
                            m_wdata[k] = m_word[k];
                            m_nwr[k]++;
                            if (k == 0) begin
                                q_addr.push_back(m_addr[k]);
                                q_data.push_back(m_wdata[k]);
                            end
                        end
                    end else begin
                        m_load[k] = 0;
                        if (data == m_csum[k]) m_done[k] = 1;
                        else                   m_err[k] = 1;
                    end
                    m_pos[k] = p + 1;
                end else if (!m_load[k] && reload) begin
                    m_load[k] = 1; m_pos[k] = 0; m_n[k] = 0;
                    m_csum[k] = 0; m_done[k] = 0; m_err[k] = 0;
                end
            end
        end
    endtask

    // Advance the model at each edge, compare the DUTs just after it
    always @(posedge clk) begin
        if (!rst) started = 1;
        model_step();
        #1;
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic g_rdy, g_we, g_cpu, g_done, g_err;
                logic [31:0] g_addr, g_wd;
                g_rdy  = (k == 0) ? rdy0 : rdy1;
                g_we   = (k == 0) ? we0 : we1;
                g_cpu  = (k == 0) ? cpu0 : cpu1;
                g_done = (k == 0) ? done0 : done1;
                g_err  = (k == 0) ? err0 : err1;
                g_addr = (k == 0) ? 32'(addr0) : 32'(addr1);
                g_wd   = (k == 0) ? wd0 : wd1;
                chk("byte_ready", k, 32'(g_rdy), 32'(m_load[k]));
                chk("imem_we", k, 32'(g_we), 32'(m_we[k]));
                chk("done", k, 32'(g_done), 32'(m_done[k]));
                chk("err", k, 32'(g_err), 32'(m_err[k]));
                chk("cpu_rst", k, 32'(g_cpu), 32'(m_done[k]));
                if (m_we[k]) begin
                    chk("imem_addr", k, g_addr, 32'(m_addr[k]));
                    chk("imem_wdata", k, g_wd, m_wdata[k]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] fw [$];

    task automatic send_byte(input logic [7:0] b, input int maxgap,
                             input bit rnd_reload);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) begin
            @(negedge clk);
            valid = 0; reload = 0; data = 8'($urandom);
        end
        @(negedge clk);
        valid = 1;
        data = b;
        reload = rnd_reload && ($urandom_range(15, 0) == 0);
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(negedge clk);
            valid = 0; reload = 0; data = 8'($urandom);
        end
    endtask

    // Sends count, words and checksum; stop_after >= 0 truncates
    task automatic send_frame(input int n, input logic [7:0] cdelta,
                              input int maxgap, input int stop_after,
                              input bit rnd_reload);
        logic [7:0] bq [$];
        logic [7:0] cs;
        logic [31:0] w;
        logic [15:0] nn;
        nn = 16'(n);
        bq.push_back(nn[7:0]);
        bq.push_back(nn[15:8]);
        for (int i = 0; i < n; i++) begin
            w = fw[i];
            for (int b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
        end
        cs = 0;
        foreach (bq[i]) cs ^= bq[i];
        bq.push_back(cs ^ cdelta);
        foreach (bq[i]) begin
            if (stop_after >= 0 && i >= stop_after) break;
            send_byte(bq[i], maxgap, rnd_reload);
        end
        idle(1);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        valid = 0; reload = 1;
        @(negedge clk);
        reload = 0;
    endtask

    task automatic do_reset(input int c);
        repeat (c) begin
            @(negedge clk);
            rst = 0; reload = 0;
            valid = 1'($urandom); data = 8'($urandom);
        end
        @(negedge clk);
        rst = 1; valid = 0;
    endtask

    task automatic rand_words(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back($urandom);
    endtask

    initial begin
        int n;
        int w0;
        rst = 0; valid = 0; data = 0; reload = 0;
        repeat (3) begin
            @(negedge clk);
            valid = 1'($urandom); data = 8'($urandom);
        end
        // reset state of the large instance
        chk("rst_ready", 0, 32'(rdy0), 32'd1);
        chk("rst_we", 0, 32'(we0), 32'd0);
        chk("rst_addr", 0, 32'(addr0), 32'd0);
        chk("rst_wdata", 0, wd0, 32'd0);
        chk("rst_cpu", 0, 32'(cpu0), 32'd0);
        chk("rst_done", 0, 32'(done0), 32'd0);
        chk("rst_err", 0, 32'(err0), 32'd0);
        rst = 1; valid = 0;

        // two known words, back-to-back
        fw.delete();
        fw.push_back(32'h00500093);
        fw.push_back(32'h00A00113);
        q_addr.delete(); q_data.delete();
        send_frame(2, 8'h00, 0, -1, 0);
        chk("A_nwr", 0, 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            chk("A_a0", 0, 32'(q_addr[0]), 32'd0);
            chk("A_d0", 0, q_data[0], 32'h00500093);
            chk("A_a1", 0, 32'(q_addr[1]), 32'd1);
            chk("A_d1", 0, q_data[1], 32'h00A00113);
        end
        chk("A_done", 0, 32'(done0), 32'd1);
        chk("A_cpu", 0, 32'(cpu0), 32'd1);

        // same frame with gaps
        pulse_reload();
        send_frame(2, 8'h00, 3, -1, 0);

        // empty program
        pulse_reload();
        w0 = m_nwr[0];
        send_frame(0, 8'h00, 0, -1, 0);
        chk("N0_nwr", 0, 32'(m_nwr[0] - w0), 32'd0);
        chk("N0_done", 0, 32'(done0), 32'd1);

        // bad checksum
        pulse_reload();
        rand_words(1);
        send_frame(1, 8'h01, 0, -1, 0);
        chk("bad_err", 0, 32'(err0), 32'd1);
        chk("bad_cpu", 0, 32'(cpu0), 32'd0);
        chk("bad_rdy", 0, 32'(rdy0), 32'd0);
        pulse_reload();
        chk("rl_err", 0, 32'(err0), 32'd0);
        chk("rl_rdy", 0, 32'(rdy0), 32'd1);

        // oversize for the small instance, fine for the large one
        pulse_reload();
        w0 = m_nwr[1];
        rand_words(5);
        send_frame(5, 8'h00, 1, -1, 0);
        chk("ovf_err", 1, 32'(err1), 32'd1);
        chk("ovf_nwr", 1, 32'(m_nwr[1] - w0), 32'd0);
        chk("ovf_big", 0, 32'(done0), 32'd1);

        // full-capacity frame for the small instance
        pulse_reload();
        rand_words(4);
        send_frame(4, 8'h00, 0, -1, 0);
        chk("full_done", 1, 32'(done1), 32'd1);

        // reset mid-frame, then a clean frame
        pulse_reload();
        rand_words(3);
        send_frame(3, 8'h00, 0, 6, 0);
        do_reset(2);
        send_frame(3, 8'h00, 0, -1, 0);
        chk("mid_done", 0, 32'(done0), 32'd1);

        // random frames
        for (int it = 0; it < 40; it++) begin
            n = int'($urandom_range(6, 0));
            rand_words(n);
            if ($urandom_range(9, 0) == 0) begin
                send_frame(n, 8'h00, 2, int'($urandom_range(8, 0)), 1);
                do_reset(int'($urandom_range(2, 1)));
            end else begin
                pulse_reload();
                send_frame(n,
                    ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1))
                                                : 8'h00,
                    int'($urandom_range(3, 0)), -1, 1);
            end
            idle(int'($urandom_range(3, 0)));
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
